intercpu_st_write: RTL and testbench



---
 rtl/intercpu_st_write_pkg.sv | 19 +
 rtl/intercpu_st_write_if.sv | 34 +++
 rtl/intercpu_st_write_rr_arb.sv | 43 ++++
 rtl/intercpu_st_write.sv | 118 +++++++++++
 tb/tb_intercpu_st_write.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/intercpu_st_write_pkg.sv
// Shared constants and helpers for the inter-CPU shared T register write side.
// Semaphore widths are only used when CRAY_ST_SEMAPHORE_EN is defined.
package intercpu_st_write_pkg;

    localparam int ST_WORDS        = 8;
    localparam int ST_WIDTH        = 64;
    localparam int ST_MAX_CLUSTERS = 5;
    localparam int SM_BITS         = 32;
    localparam int ST_BUS          = ST_WORDS * ST_WIDTH;

    typedef logic [ST_WIDTH-1:0] st_word_t;
    typedef logic [ST_BUS-1:0]   st_bus_t;

    // Cluster 0 and clusters above the implemented count are accepted but never stored.
    function automatic logic cln_valid(input logic [2:0] cln, input logic [2:0] ncl);
        return (cln != 3'd0) && (cln <= ncl);
    endfunction

endpackage

// File: rtl/intercpu_st_write_if.sv
// CPU-side request bus and per-cluster ST buses; semaphore signals exist only
// with CRAY_ST_SEMAPHORE_EN.
interface intercpu_st_write_if
    import intercpu_st_write_pkg::*;
#(
    parameter int NUM_CPUS = 2
);
    logic [NUM_CPUS-1:0]   wr_req;
    logic [3*NUM_CPUS-1:0] cln;
    logic [3*NUM_CPUS-1:0] j;
    logic [64*NUM_CPUS-1:0] data;
    logic [NUM_CPUS-1:0]   wr_ack;
    st_bus_t st_1, st_2, st_3, st_4, st_5;
`ifdef CRAY_ST_SEMAPHORE_EN
    logic [NUM_CPUS-1:0]   sm_op;
    logic [NUM_CPUS-1:0]   sm_clr;
    logic [5*NUM_CPUS-1:0] sm_idx;
    logic [NUM_CPUS-1:0]   sm_old;
    logic [SM_BITS-1:0]    sm_1, sm_2, sm_3, sm_4, sm_5;

    modport master (output wr_req, cln, j, data, sm_op, sm_clr, sm_idx,
                    input  wr_ack, st_1, st_2, st_3, st_4, st_5,
                           sm_old, sm_1, sm_2, sm_3, sm_4, sm_5);
    modport slave  (input  wr_req, cln, j, data, sm_op, sm_clr, sm_idx,
                    output wr_ack, st_1, st_2, st_3, st_4, st_5,
                           sm_old, sm_1, sm_2, sm_3, sm_4, sm_5);
`else
    modport master (output wr_req, cln, j, data,
                    input  wr_ack, st_1, st_2, st_3, st_4, st_5);
    modport slave  (input  wr_req, cln, j, data,
                    output wr_ack, st_1, st_2, st_3, st_4, st_5);
`endif

endinterface

// File: rtl/intercpu_st_write_rr_arb.sv
// Round-robin arbiter: one-hot grant, priority starts one past the last grant.
module intercpu_rr_arb #(
    parameter int NUM_CPUS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CPUS-1:0] req,
    output logic [NUM_CPUS-1:0] gnt,
    output logic                gnt_valid
);
    localparam int PW = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;

    logic [PW-1:0]         ptr;
    logic [2*NUM_CPUS-1:0] req_rot;
    logic [2*NUM_CPUS-1:0] gnt_wide;
    logic [NUM_CPUS-1:0]   pick;

    // Rotate requests so bit 0 is the highest-priority CPU, pick, then rotate back.
    always_comb begin
        req_rot   = {req, req} >> ptr;
        pick      = '0;
        gnt_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_CPUS; i++) begin
            if (!gnt_valid && req_rot[i]) begin
                pick[i]   = 1'b1;
                gnt_valid = 1'b1;
            end
        end
        gnt_wide = {{NUM_CPUS{1'b0}}, pick} << ptr;
        gnt      = gnt_wide[NUM_CPUS-1:0] | gnt_wide[2*NUM_CPUS-1:NUM_CPUS];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_valid) begin
            for (int unsigned i = 0; i < NUM_CPUS; i++) begin
                if (gnt[i]) ptr <= (i == NUM_CPUS - 1) ? '0 : PW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/intercpu_st_write.sv
// Inter-CPU shared T register storage and write arbitration.
// Optional semaphore registers are built when CRAY_ST_SEMAPHORE_EN is defined.
module intercpu_st_write
    import intercpu_st_write_pkg::*;
#(
    parameter int NUM_CPUS     = 2,
    parameter int NUM_CLUSTERS = 5
) (
    input logic               clk,
    input logic               rst,
    intercpu_st_write_if.slave bus
);
    localparam logic [2:0] NCL = 3'(NUM_CLUSTERS);

    logic [NUM_CPUS-1:0] ack_q;
    logic [NUM_CPUS-1:0] eligible;
    logic [NUM_CPUS-1:0] gnt;
    logic                gnt_valid;
    logic [2:0]          sel_cln, sel_j, sel_cidx;
    st_word_t            sel_data;
    logic                sel_hit, sel_sm;
    st_word_t            mem  [ST_MAX_CLUSTERS][ST_WORDS];
    st_bus_t             flat [ST_MAX_CLUSTERS];

    // A CPU whose ack is showing must not be granted again for the same request.
    assign eligible = bus.wr_req & ~ack_q;

    intercpu_rr_arb #(.NUM_CPUS(NUM_CPUS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (eligible),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        sel_cln  = '0;
        sel_j    = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_CPUS; k++) begin
            if (gnt[k]) begin
                sel_cln  = bus.cln[3*k +: 3];
                sel_j    = bus.j[3*k +: 3];
                sel_data = bus.data[64*k +: 64];
            end
        end
        sel_cidx = sel_cln - 3'd1;
        sel_hit  = cln_valid(sel_cln, NCL);
    end

`ifdef CRAY_ST_SEMAPHORE_EN
    logic [SM_BITS-1:0]  sm [ST_MAX_CLUSTERS];
    logic [NUM_CPUS-1:0] old_q;
    logic                sel_clr, sel_old;
    logic [4:0]          sel_idx;

    always_comb begin
        sel_sm  = 1'b0;
        sel_clr = 1'b0;
        sel_idx = '0;
        for (int unsigned k = 0; k < NUM_CPUS; k++) begin
            if (gnt[k]) begin
                sel_sm  = bus.sm_op[k];
                sel_clr = bus.sm_clr[k];
                sel_idx = bus.sm_idx[5*k +: 5];
            end
        end
        sel_old = sel_hit ? sm[sel_cidx][sel_idx] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sm    <= '{default: '0};
            old_q <= '0;
        end else if (gnt_valid && sel_sm) begin
            old_q <= (old_q & ~gnt) | (gnt & {NUM_CPUS{sel_old}});
            if (sel_hit) sm[sel_cidx][sel_idx] <= !sel_clr;
        end
    end

    assign bus.sm_old = old_q;
    assign bus.sm_1   = (NUM_CLUSTERS >= 1) ? sm[0] : '0;
    assign bus.sm_2   = (NUM_CLUSTERS >= 2) ? sm[1] : '0;
    assign bus.sm_3   = (NUM_CLUSTERS >= 3) ? sm[2] : '0;
    assign bus.sm_4   = (NUM_CLUSTERS >= 4) ? sm[3] : '0;
    assign bus.sm_5   = (NUM_CLUSTERS >= 5) ? sm[4] : '0;
`else
    assign sel_sm = 1'b0;
`endif

    // Reset wins over a same-cycle grant: the write and its ack are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem   <= '{default: '0};
            ack_q <= '0;
        end else begin
            ack_q <= gnt;
            if (gnt_valid && sel_hit && !sel_sm) mem[sel_cidx][sel_j] <= sel_data;
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < ST_MAX_CLUSTERS; c++) begin
            flat[c] = '0;
            for (int unsigned w = 0; w < ST_WORDS; w++) begin
                flat[c][ST_WIDTH*w +: ST_WIDTH] = mem[c][w];
            end
        end
    end

    assign bus.wr_ack = ack_q;
    assign bus.st_1   = (NUM_CLUSTERS >= 1) ? flat[0] : '0;
    assign bus.st_2   = (NUM_CLUSTERS >= 2) ? flat[1] : '0;
    assign bus.st_3   = (NUM_CLUSTERS >= 3) ? flat[2] : '0;
    assign bus.st_4   = (NUM_CLUSTERS >= 4) ? flat[3] : '0;
    assign bus.st_5   = (NUM_CLUSTERS >= 5) ? flat[4] : '0;

endmodule

// File: tb/tb_intercpu_st_write.sv
// Directed bench for intercpu_st_write with two CPUs and five clusters.
// The semaphore sequence is included when CRAY_ST_SEMAPHORE_EN is defined.
module tb_intercpu_st_write;
    import intercpu_st_write_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    st_bus_t e1, e2, e3, e4, e5;

    always #5 clk = ~clk;

    intercpu_st_write_if #(.NUM_CPUS(2)) bus ();

    intercpu_st_write #(.NUM_CPUS(2), .NUM_CLUSTERS(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input int k, input logic req, input logic [2:0] c,
                           input logic [2:0] jj, input logic [63:0] d);
        bus.wr_req[k]      = req;
        bus.cln[3*k +: 3]  = c;
        bus.j[3*k +: 3]    = jj;
        bus.data[64*k +: 64] = d;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_st1"}, bus.st_1, e1);
        chk({tag, "_st2"}, bus.st_2, e2);
        chk({tag, "_st3"}, bus.st_3, e3);
        chk({tag, "_st4"}, bus.st_4, e4);
        chk({tag, "_st5"}, bus.st_5, e5);
    endtask

    initial begin
        bus.wr_req = '0;
        bus.cln    = '0;
        bus.j      = '0;
        bus.data   = '0;
`ifdef CRAY_ST_SEMAPHORE_EN
        bus.sm_op  = '0;
        bus.sm_clr = '0;
        bus.sm_idx = '0;
`endif
        e1 = '0; e2 = '0; e3 = '0; e4 = '0; e5 = '0;

        // Reset state
        tick();
        tick();
        chk("rst_ack", bus.wr_ack, 2'b00);
        chk_all("rst");
        rst = 1'b0;

        // Single write, cluster 1 word 3
        set_cpu(0, 1'b1, 3'd1, 3'd3, 64'hDEAD_BEEF_0123_4567);
        tick();
        chk("t1_ack", bus.wr_ack, 2'b01);
        e1 = st_bus_t'(64'hDEAD_BEEF_0123_4567) << 192;
        chk_all("t1");
        tick();
        chk("t1_ack_once", bus.wr_ack, 2'b00);
        set_cpu(0, 1'b0, 3'd0, 3'd0, 64'd0);

        // Reset again so CPU0 has priority for the same-word collision
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e1 = '0;
        chk("t2_rst_st1", bus.st_1, e1);

        set_cpu(0, 1'b1, 3'd2, 3'd0, 64'd1);
        set_cpu(1, 1'b1, 3'd2, 3'd0, 64'd2);
        tick();
        chk("t2_ack_c1", bus.wr_ack, 2'b01);
        chk("t2_st2_c1", bus.st_2, 512'd1);
        tick();
        chk("t2_ack_c2", bus.wr_ack, 2'b10);
        chk("t2_st2_c2", bus.st_2, 512'd2);
        set_cpu(0, 1'b0, 3'd0, 3'd0, 64'd0);
        tick();
        chk("t2_ack_c3", bus.wr_ack, 2'b00);
        e2 = 512'd2;
        chk("t2_st2_c3", bus.st_2, e2);
        set_cpu(1, 1'b0, 3'd0, 3'd0, 64'd0);

        // Continuous requests alternate between CPUs
        set_cpu(0, 1'b1, 3'd3, 3'd1, 64'h1111);
        set_cpu(1, 1'b1, 3'd4, 3'd2, 64'h2222);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t3_ack_%0d", i), bus.wr_ack, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        set_cpu(0, 1'b0, 3'd0, 3'd0, 64'd0);
        set_cpu(1, 1'b0, 3'd0, 3'd0, 64'd0);
        e3 = st_bus_t'(64'h1111) << 64;
        e4 = st_bus_t'(64'h2222) << 128;
        chk_all("t3");
        tick();
        chk("t3_ack_idle", bus.wr_ack, 2'b00);

        // Cluster 0 and cluster 6 are acked without storage change
        set_cpu(1, 1'b1, 3'd0, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("t4_ack_cln0", bus.wr_ack, 2'b10);
        chk_all("t4_cln0");
        set_cpu(1, 1'b1, 3'd6, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("t4_ack_gap", bus.wr_ack, 2'b00);
        tick();
        chk("t4_ack_cln6", bus.wr_ack, 2'b10);
        chk_all("t4_cln6");
        set_cpu(1, 1'b0, 3'd0, 3'd0, 64'd0);
        tick();

        // Move the pointer to CPU1, then reset during a CPU1 grant
        set_cpu(0, 1'b1, 3'd1, 3'd0, 64'd5);
        tick();
        chk("t5_pre_ack", bus.wr_ack, 2'b01);
        set_cpu(0, 1'b0, 3'd0, 3'd0, 64'd0);
        tick();
        set_cpu(1, 1'b1, 3'd3, 3'd7, 64'hAAAA_5555_AAAA_5555);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e1 = '0; e2 = '0; e3 = '0; e4 = '0; e5 = '0;
        chk("t5_rst_ack", bus.wr_ack, 2'b00);
        chk_all("t5_rst");
        set_cpu(0, 1'b1, 3'd5, 3'd0, 64'h0BAD_F00D);
        tick();
        chk("t5_next_cpu0", bus.wr_ack, 2'b01);
        e5 = 512'h0BAD_F00D;
        chk("t5_st5", bus.st_5, e5);
        set_cpu(0, 1'b0, 3'd0, 3'd0, 64'd0);
        tick();
        chk("t5_reissue_ack", bus.wr_ack, 2'b10);
        e3 = st_bus_t'(64'hAAAA_5555_AAAA_5555) << 448;
        chk_all("t5_reissue");
        set_cpu(1, 1'b0, 3'd0, 3'd0, 64'd0);
        tick();

`ifdef CRAY_ST_SEMAPHORE_EN
        // Test-and-set twice, then clear, on cluster 1 bit 5
        chk("sm_rst", bus.sm_1, 32'd0);
        set_cpu(0, 1'b1, 3'd1, 3'd0, 64'hFFFF);
        bus.sm_op[0]    = 1'b1;
        bus.sm_clr[0]   = 1'b0;
        bus.sm_idx[4:0] = 5'd5;
        tick();
        chk("sm_tas1_ack", bus.wr_ack, 2'b01);
        chk("sm_tas1_old", bus.sm_old, 2'b00);
        chk("sm_tas1_reg", bus.sm_1, 32'h20);
        tick();
        tick();
        chk("sm_tas2_ack", bus.wr_ack, 2'b01);
        chk("sm_tas2_old", bus.sm_old, 2'b01);
        chk("sm_tas2_reg", bus.sm_1, 32'h20);
        bus.sm_clr[0] = 1'b1;
        tick();
        tick();
        chk("sm_clr_ack", bus.wr_ack, 2'b01);
        chk("sm_clr_old", bus.sm_old, 2'b01);
        chk("sm_clr_reg", bus.sm_1, 32'h0);
        chk_all("sm_words");
        set_cpu(0, 1'b0, 3'd0, 3'd0, 64'd0);
        bus.sm_op = '0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
